dp_requant_packer: RTL and testbench
====================================

# dp_requant_packer

Downstream stage of the dot-product engine. Consumes the stream of 32-bit ReLU'd dot-product results and requantizes each result to 8 bits with a rounding arithmetic right shift and unsigned saturation. Packs four quantized values per 32-bit output beat and drives an HWPE output stream toward the streamer/TCDM, with per-byte strobes on the final partial beat of a tile.

## Interface
Parameters:
- IN_WORD, 32: width of one input result (equals WORD_SIZE).
- OUT_WORD, 8: width of one quantized value.
- LANES, 4: quantized values per output beat (32 / OUT_WORD).
- CNT_W, 16: width of the element counter.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- test_mode_i, in, 1: unused, reserved.
- res_i, hwpe_stream sink, DATA_WIDTH 32: one signed IN_WORD result per beat.
- pk_o, hwpe_stream source, DATA_WIDTH 32: packed output, lane k in bits [8k+7:8k]; strb per byte.
- ctrl_i, in, ctrl_requant_t: fields start, clear, shift[4:0], count[CNT_W-1:0].
- flags_o, out, flags_requant_t: fields done, elem_cnt[CNT_W-1:0].

## Operation
- Idle after reset. ctrl_i.start or ctrl_i.clear zeroes elem_cnt, lane_idx and pack_reg, drops pk_o.valid and clears done. start additionally arms the tile; count and shift must be held stable until done.
- Per accepted input x (signed 32-bit):
  - r = (shift == 0) ? 0 : 1 << (shift-1).
  - y = (x + r) >>> shift, computed in 33 bits so the add cannot overflow.
  - q = 0 if y < 0, 255 if y > 255, otherwise y[7:0].
- q is written into pack_reg lane lane_idx. Then lane_idx increments and elem_cnt increments.
- Beat completion happens when lane_idx == 3 or elem_cnt == count-1 (last element):
  - pack_reg with the new lane moves to the output register.
  - strb = 4'b1111 for a full beat, or one bit per filled lane from bit 0 for a partial last beat.
  - Unfilled lanes are 0.
  - lane_idx wraps to 0 and pack_reg clears.
- After the last element, done = 1 (sticky) and further inputs are refused: res_i.ready = 0 until the next start.
- count == 0: done is set the cycle after start, and no beat is emitted.
- elem_cnt reflects accepted inputs and saturates at count.

## Timing
- Reset values: pk_o.valid = 0, pk_o.data = 0, pk_o.strb = 0, flags_o.done = 0, flags_o.elem_cnt = 0, res_i.ready = 0.
- res_i.ready = armed & ~done & (~pk_o.valid | pk_o.ready). This is combinational from the output register state and is never dependent on res_i.valid.
- Latency: the completing input handshake in cycle N puts pk_o.valid = 1 with data in cycle N+1.
- Sustained throughput is 1 input per cycle with pk_o.ready held high, i.e. 1 output beat per 4 inputs.
- pk_o.valid, data and strb hold stable until the pk_o handshake. valid drops the cycle after the handshake unless a new beat completes in the same cycle, in which case the new beat is loaded.
- done rises in the cycle after the last input handshake, together with the last beat's valid. Downstream must still drain that beat; done does not imply drained.
- Precedence when simultaneous: clear > start > handshakes. A start in the same cycle as an input handshake discards that input.
- Reset mid-tile discards all partial and pending data.

## Structure
- dp_package gains ctrl_requant_t, flags_requant_t, REQ_OUT_WORD = 8 and REQ_LANES = 4.
- The combinational round/shift/saturate datapath is its own sub-module, dp_requant_lane: inputs x and shift, output q.
- The top holds the counters, the pack register, the output register and the handshake logic.

## Test plan
- Quantization: shift = 4, inputs 0, 8, 23, 4095 -> lanes 0, 1, 1, 255 (4095 clipped). Expect one beat 0xFF010100, strb 4'b1111.
- Negatives and shift 0: shift = 0, inputs -5, 255, 256, 7 -> 0x07FF FF00... checked per lane as 0, 255, 255, 7.
- Partial last beat: count = 6, shift = 0, inputs 1..6 -> beats 0x04030201 strb 1111, then 0x00000605 strb 0011. done rises with the second valid; a 7th input sees ready = 0.
- Backpressure: pk_o.ready low for 5 cycles while a beat is pending -> res_i.ready = 0 throughout. No data loss, valid and data stable. Full throughput resumes after the release.
- clear mid-tile: clear asserted after 2 of 4 inputs -> no beat emitted. A following start with count = 4 produces exactly one correct beat.
- count = 0 -> done = 1 one cycle after start, pk_o.valid never asserted.

Source files
------------

// File: rtl/dp_requant_packer_pkg.sv
// Shared types and constants for the requantize-and-pack output stage of the dot-product engine.
package dp_requant_packer_pkg;

    localparam int unsigned REQ_IN_WORD  = 32;
    localparam int unsigned REQ_OUT_WORD = 8;
    localparam int unsigned REQ_LANES    = 4;
    localparam int unsigned REQ_CNT_W    = 16;

    typedef struct packed {
        logic                 start;
        logic                 clear;
        logic [4:0]           shift;
        logic [REQ_CNT_W-1:0] count;
    } ctrl_requant_t;

    typedef struct packed {
        logic                 done;
        logic [REQ_CNT_W-1:0] elem_cnt;
    } flags_requant_t;

    typedef enum logic [1:0] {
        RQ_IDLE,
        RQ_RUN,
        RQ_DONE
    } rq_state_e;

    // Byte strobe covering lanes 0..last_lane inclusive.
    function automatic logic [REQ_LANES-1:0] lane_strb(input logic [1:0] last_lane);
        lane_strb = '0;
        for (int unsigned i = 0; i < REQ_LANES; i++) begin
            if (i <= 32'(last_lane)) lane_strb[i] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/dp_requant_packer_lane.sv
// Combinational requantizer: rounding arithmetic right shift then unsigned saturation to OUT_WORD bits.
module dp_requant_lane #(
    parameter int unsigned IN_WORD  = 32,
    parameter int unsigned OUT_WORD = 8
) (
    input  logic [IN_WORD-1:0]  x_i,
    input  logic [4:0]          shift_i,
    output logic [OUT_WORD-1:0] q_o
);

    localparam logic signed [IN_WORD:0] QMAX = (IN_WORD+1)'((1 << OUT_WORD) - 1);

    logic signed [IN_WORD:0] x_ext;
    logic signed [IN_WORD:0] rnd;
    logic signed [IN_WORD:0] sum;
    logic signed [IN_WORD:0] y;

    // One extra bit so x + rounding bias can never wrap.
    always_comb begin
        x_ext = {x_i[IN_WORD-1], x_i};
        rnd   = '0;
        if (shift_i != '0) rnd = (IN_WORD+1)'(1) << (shift_i - 5'd1);
        sum = x_ext + rnd;
        y   = sum >>> shift_i;
        if (y < 0)         q_o = '0;
        else if (y > QMAX) q_o = '1;
        else               q_o = y[OUT_WORD-1:0];
    end

endmodule

// File: rtl/dp_requant_packer.sv
// Requantizes the 32-bit result stream to bytes and packs four per output beat, with strobes on a tile's final partial beat.
module dp_requant_packer
    import dp_requant_packer_pkg::*;
#(
    parameter int unsigned IN_WORD  = REQ_IN_WORD,
    parameter int unsigned OUT_WORD = REQ_OUT_WORD,
    parameter int unsigned LANES    = REQ_LANES,
    parameter int unsigned CNT_W    = REQ_CNT_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_mode_i,
    input  logic                      res_valid_i,
    input  logic [IN_WORD-1:0]        res_data_i,
    output logic                      res_ready_o,
    output logic                      pk_valid_o,
    output logic [LANES*OUT_WORD-1:0] pk_data_o,
    output logic [LANES-1:0]          pk_strb_o,
    input  logic                      pk_ready_i,
    input  ctrl_requant_t             ctrl_i,
    output flags_requant_t            flags_o
);

    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned PACK_W = LANES * OUT_WORD;

    rq_state_e            state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PACK_W-1:0]    pack_q, pack_d;
    logic                 vld_q, vld_d;
    logic [PACK_W-1:0]    data_q, data_d;
    logic [LANES-1:0]     strb_q, strb_d;

    logic [OUT_WORD-1:0]  q;
    logic [PACK_W-1:0]    pack_new;
    logic                 in_hs, out_hs, last, beat_done;
    logic                 unused_test_mode;

    assign unused_test_mode = test_mode_i;

    dp_requant_lane #(
        .IN_WORD  (IN_WORD),
        .OUT_WORD (OUT_WORD)
    ) i_lane (
        .x_i     (res_data_i),
        .shift_i (ctrl_i.shift),
        .q_o     (q)
    );

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        pack_d   = pack_q;
        vld_d    = vld_q;
        data_d   = data_q;
        strb_d   = strb_q;

        res_ready_o = (state_q == RQ_RUN) & (~vld_q | pk_ready_i);
        in_hs       = res_valid_i & res_ready_o;
        out_hs      = vld_q & pk_ready_i;
        last        = (cnt_q == ctrl_i.count - 1'b1);
        beat_done   = in_hs & ((lane_q == LANE_W'(LANES - 1)) | last);

        pack_new = pack_q;
        pack_new[lane_q*OUT_WORD +: OUT_WORD] = q;

        if (out_hs) vld_d = 1'b0;

        if (in_hs) begin
            pack_d = pack_new;
            lane_d = lane_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (beat_done) begin
                vld_d  = 1'b1;
                data_d = pack_new;
                strb_d = lane_strb(lane_q);
                lane_d = '0;
                pack_d = '0;
            end
            if (last) state_d = RQ_DONE;
        end

        // clear outranks start, and both discard any input accepted this cycle.
        if (ctrl_i.start) begin
            cnt_d   = '0;
            lane_d  = '0;
            pack_d  = '0;
            vld_d   = 1'b0;
            state_d = (ctrl_i.count == '0) ? RQ_DONE : RQ_RUN;
        end
        if (ctrl_i.clear) begin
            cnt_d   = '0;
            lane_d  = '0;
            pack_d  = '0;
            vld_d   = 1'b0;
            state_d = RQ_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RQ_IDLE;
            lane_q  <= '0;
            cnt_q   <= '0;
            pack_q  <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

    assign pk_valid_o       = vld_q;
    assign pk_data_o        = data_q;
    assign pk_strb_o        = strb_q;
    assign flags_o.done     = (state_q == RQ_DONE);
    assign flags_o.elem_cnt = cnt_q;

endmodule

// File: tb/tb_dp_requant_packer.sv
// Randomized self-checking bench for dp_requant_packer against an arithmetic reference model.
module tb_dp_requant_packer;
    import dp_requant_packer_pkg::*;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           test_mode_i;
    logic           res_valid_i;
    logic [31:0]    res_data_i;
    logic           res_ready_o;
    logic           pk_valid_o;
    logic [31:0]    pk_data_o;
    logic [3:0]     pk_strb_o;
    logic           pk_ready_i;
    ctrl_requant_t  ctrl_i;
    flags_requant_t flags_o;

    dp_requant_packer #(
        .IN_WORD  (32),
        .OUT_WORD (8),
        .LANES    (4),
        .CNT_W    (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode_i),
        .res_valid_i (res_valid_i),
        .res_data_i  (res_data_i),
        .res_ready_o (res_ready_o),
        .pk_valid_o  (pk_valid_o),
        .pk_data_o   (pk_data_o),
        .pk_strb_o   (pk_strb_o),
        .pk_ready_i  (pk_ready_i),
        .ctrl_i      (ctrl_i),
        .flags_o     (flags_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    bit          hs_in;
    logic [35:0] got_q[$];   // {strb, data} of each drained beat
    logic [35:0] exp_q[$];
    logic [31:0] stim[$];

    // Reference: floor((x + r) / 2^shift) then clamp to [0,255].
    function automatic logic [7:0] ref_quant(input logic [31:0] x, input int unsigned sh);
        longint v;
        longint r;
        r = (sh == 0) ? 64'sd0 : (longint'(1) << (sh - 1));
        v = (longint'($signed(x)) + r) >>> sh;
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic void build_exp(input int unsigned sh);
        logic [31:0] w;
        int unsigned n;
        exp_q.delete();
        w = '0;
        n = 0;
        foreach (stim[i]) begin
            w[8*n +: 8] = ref_quant(stim[i], sh);
            n++;
            if (n == 4 || i == stim.size() - 1) begin
                exp_q.push_back({4'((1 << n) - 1), w});
                w = '0;
                n = 0;
            end
        end
    endfunction

    function automatic logic [31:0] rand_word(input int unsigned sh);
        case ($urandom_range(3))
            0: return 32'($urandom_range(300));
            1: return -32'($urandom_range(100000));
            2: return 32'($urandom);
            default: return 32'($urandom_range(1 << ((sh > 20) ? 30 : sh + 9)));
        endcase
    endfunction

    // Inputs are driven just after an edge; sample mid-cycle, then advance one clock.
    task automatic tick();
        #1;
        hs_in = res_valid_i && res_ready_o;
        if (pk_valid_o && pk_ready_i) got_q.push_back({pk_strb_o, pk_data_o});
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_tile(input int unsigned count, input int unsigned sh);
        ctrl_i.start = 1'b1;
        ctrl_i.count = 16'(count);
        ctrl_i.shift = 5'(sh);
        res_valid_i  = 1'b0;
        tick();
        ctrl_i.start = 1'b0;
        got_q.delete();
    endtask

    task automatic run_stream(input int unsigned pvalid, input int unsigned pready, output bit timeout);
        int unsigned idx;
        int unsigned cyc;
        idx = 0;
        cyc = 0;
        while ((idx < stim.size() || pk_valid_o) && cyc < 2000) begin
            res_valid_i = (idx < stim.size()) && ($urandom_range(99) < pvalid);
            res_data_i  = (idx < stim.size()) ? stim[idx] : 32'h0;
            pk_ready_i  = ($urandom_range(99) < pready);
            tick();
            if (hs_in) idx++;
            cyc++;
        end
        res_valid_i = 1'b0;
        pk_ready_i  = 1'b1;
        timeout = (cyc >= 2000);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++; if (pk_valid_o !== 1'b0)       begin n_err++; $display("FAIL reset_valid: got %b want 0", pk_valid_o); end
        n_cmp++; if (pk_data_o !== 32'h0)       begin n_err++; $display("FAIL reset_data: got %h want 0", pk_data_o); end
        n_cmp++; if (pk_strb_o !== 4'h0)        begin n_err++; $display("FAIL reset_strb: got %b want 0", pk_strb_o); end
        n_cmp++; if (flags_o.done !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b want 0", flags_o.done); end
        n_cmp++; if (flags_o.elem_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", flags_o.elem_cnt); end
        n_cmp++; if (res_ready_o !== 1'b0)      begin n_err++; $display("FAIL reset_ready: got %b want 0", res_ready_o); end
        rst_ni = 1'b1;
        res_valid_i = 1'b1;
        tick();
        n_cmp++; if (res_ready_o !== 1'b0)      begin n_err++; $display("FAIL idle_ready: got %b want 0", res_ready_o); end
        res_valid_i = 1'b0;
    endtask

    task automatic test_fixed_tile(input string name, input int unsigned sh,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c, input logic [31:0] d,
                                   input logic [35:0] hand);
        bit to;
        stim = '{a, b, c, d};
        build_exp(sh);
        start_tile(4, sh);
        run_stream(100, 100, to);
        n_cmp++; if (to)                        begin n_err++; $display("FAIL %s_timeout: got timeout want drain", name); end
        n_cmp++; if (got_q.size() !== 1)        begin n_err++; $display("FAIL %s_beats: got %0d want 1", name, got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== hand)     begin n_err++; $display("FAIL %s_beat: got %h want %h", name, got_q[0], hand); end
            n_cmp++; if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL %s_model: got %h want %h", name, got_q[0], exp_q[0]); end
        end
        n_cmp++; if (flags_o.done !== 1'b1)     begin n_err++; $display("FAIL %s_done: got %b want 1", name, flags_o.done); end
        n_cmp++; if (flags_o.elem_cnt !== 16'd4) begin n_err++; $display("FAIL %s_cnt: got %0d want 4", name, flags_o.elem_cnt); end
    endtask

    task automatic test_partial();
        start_tile(6, 0);
        pk_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            res_valid_i = 1'b1;
            res_data_i  = 32'(i + 1);
            tick();
            n_cmp++; if (!hs_in) begin n_err++; $display("FAIL partial_accept%0d: got 0 want 1", i); end
            if (i == 3) begin
                n_cmp++; if ({pk_valid_o, pk_strb_o, pk_data_o} !== {1'b1, 4'hF, 32'h04030201})
                    begin n_err++; $display("FAIL partial_beat0: got %b %b %h want 1 1111 04030201", pk_valid_o, pk_strb_o, pk_data_o); end
                n_cmp++; if (flags_o.done !== 1'b0) begin n_err++; $display("FAIL partial_early_done: got 1 want 0"); end
            end
        end
        n_cmp++; if ({pk_valid_o, pk_strb_o, pk_data_o} !== {1'b1, 4'b0011, 32'h00000605})
            begin n_err++; $display("FAIL partial_beat1: got %b %b %h want 1 0011 00000605", pk_valid_o, pk_strb_o, pk_data_o); end
        n_cmp++; if (flags_o.done !== 1'b1) begin n_err++; $display("FAIL partial_done: got %b want 1", flags_o.done); end
        res_data_i = 32'd7;
        tick();
        n_cmp++; if (hs_in) begin n_err++; $display("FAIL partial_7th_ready: got 1 want 0"); end
        tick();
        n_cmp++; if (flags_o.elem_cnt !== 16'd6) begin n_err++; $display("FAIL partial_cnt: got %0d want 6", flags_o.elem_cnt); end
        res_valid_i = 1'b0;
    endtask

    task automatic test_backpressure();
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(rand_word(3));
        build_exp(3);
        start_tile(8, 3);
        pk_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            res_valid_i = 1'b1;
            res_data_i  = stim[i];
            tick();
        end
        res_data_i = stim[4];
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (hs_in) begin n_err++; $display("FAIL bp_ready%0d: got 1 want 0", c); end
            n_cmp++; if ({pk_valid_o, pk_strb_o, pk_data_o} !== {1'b1, exp_q[0]})
                begin n_err++; $display("FAIL bp_hold%0d: got %b %h want 1 %h", c, pk_valid_o, {pk_strb_o, pk_data_o}, exp_q[0]); end
        end
        pk_ready_i = 1'b1;
        for (int i = 4; i < 8; i++) begin
            res_data_i = stim[i];
            tick();
            n_cmp++; if (!hs_in) begin n_err++; $display("FAIL bp_throughput%0d: got 0 want 1", i); end
        end
        res_valid_i = 1'b0;
        tick();
        n_cmp++; if (got_q.size() !== 2) begin n_err++; $display("FAIL bp_beats: got %0d want 2", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_clear();
        bit to;
        start_tile(4, 1);
        pk_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            res_valid_i = 1'b1;
            res_data_i  = 32'(10 + i);
            tick();
        end
        res_valid_i  = 1'b0;
        ctrl_i.clear = 1'b1;
        tick();
        ctrl_i.clear = 1'b0;
        for (int c = 0; c < 3; c++) begin
            res_valid_i = 1'b1;
            tick();
            n_cmp++; if (pk_valid_o !== 1'b0 || hs_in) begin n_err++; $display("FAIL clear_idle%0d: got valid %b hs %b want 0 0", c, pk_valid_o, hs_in); end
        end
        res_valid_i = 1'b0;
        n_cmp++; if (flags_o.elem_cnt !== 16'd0) begin n_err++; $display("FAIL clear_cnt: got %0d want 0", flags_o.elem_cnt); end
        n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL clear_no_beat: got %0d want 0", got_q.size()); end
        stim.delete();
        for (int i = 0; i < 4; i++) stim.push_back(rand_word(2));
        build_exp(2);
        start_tile(4, 2);
        run_stream(100, 100, to);
        n_cmp++; if (got_q.size() !== 1 || to) begin n_err++; $display("FAIL clear_restart_beats: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL clear_restart: got %h want %h", got_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_start_discard();
        bit to;
        start_tile(4, 0);
        pk_ready_i  = 1'b1;
        res_valid_i = 1'b1;
        res_data_i  = 32'd99;
        tick();
        res_data_i   = 32'd77;
        ctrl_i.start = 1'b1;
        tick();
        ctrl_i.start = 1'b0;
        res_valid_i  = 1'b0;
        got_q.delete();
        stim = '{32'd1, 32'd2, 32'd3, 32'd4};
        build_exp(0);
        run_stream(100, 100, to);
        n_cmp++; if (got_q.size() !== 1 || to) begin n_err++; $display("FAIL restart_beats: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== 36'hF_04030201) begin n_err++; $display("FAIL restart_discard: got %h want f04030201", got_q[0]); end
        end
    endtask

    task automatic test_count0();
        bit seen;
        start_tile(0, 0);
        n_cmp++; if (flags_o.done !== 1'b1) begin n_err++; $display("FAIL cnt0_done: got %b want 1", flags_o.done); end
        seen = 1'b0;
        res_valid_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (pk_valid_o || hs_in) seen = 1'b1;
        end
        res_valid_i = 1'b0;
        n_cmp++; if (seen) begin n_err++; $display("FAIL cnt0_quiet: got activity want none"); end
    endtask

    task automatic test_random();
        bit to;
        int unsigned cnt;
        int unsigned sh;
        for (int t = 0; t < 12; t++) begin
            cnt = $urandom_range(13, 1);
            sh  = $urandom_range(31);
            stim.delete();
            for (int unsigned i = 0; i < cnt; i++) stim.push_back(rand_word(sh));
            build_exp(sh);
            start_tile(cnt, sh);
            run_stream(70, 60, to);
            n_cmp++; if (to) begin n_err++; $display("FAIL rand%0d_timeout: got timeout want drain", t); end
            n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand%0d_beats: got %0d want %0d", t, got_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_beat%0d: got %h want %h", t, i, got_q[i], exp_q[i]); end
            end
            n_cmp++; if (flags_o.done !== 1'b1 || flags_o.elem_cnt !== 16'(cnt))
                begin n_err++; $display("FAIL rand%0d_flags: got done %b cnt %0d want 1 %0d", t, flags_o.done, flags_o.elem_cnt, cnt); end
        end
    endtask

    initial begin
        test_mode_i = 1'b0;
        res_valid_i = 1'b0;
        res_data_i  = '0;
        pk_ready_i  = 1'b0;
        ctrl_i      = '0;
        test_reset();
        test_fixed_tile("quant", 4, 32'd0, 32'd8, 32'd23, 32'd4095, 36'hF_FF010100);
        test_fixed_tile("neg_shift0", 0, -32'sd5, 32'd255, 32'd256, 32'd7, 36'hF_07FFFF00);
        test_partial();
        test_backpressure();
        test_clear();
        test_start_discard();
        test_count0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
